// File: rtl/spi_sensor_pkg.sv
// Shared constants for the SPI sample scheduler: sensor selects, the fixed
// slot table and the FSM state encoding.
package spi_sensor_pkg;

  localparam int   NUM_SLOTS = 5;
  localparam logic GYRO      = 1'b0;
  localparam logic ACCL      = 1'b1;

  typedef logic [2:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PUBLISH
  } state_e;

  // One row of the slot table, in the bit order of the SPI master command.
  typedef struct packed {
    logic       sel;
    logic [7:0] cmd;
    logic [2:0] len;
  } slot_cfg_t;

  // Fixed read order: gyro X/Y (3-byte reads), then accel X/Y/Z (4-byte reads).
  function automatic slot_cfg_t slot_cfg(input slot_t s);
    case (s)
      3'd0:    return '{sel: GYRO, cmd: 8'h02, len: 3'd3};
      3'd1:    return '{sel: GYRO, cmd: 8'h04, len: 3'd3};
      3'd2:    return '{sel: ACCL, cmd: 8'h12, len: 3'd4};
      3'd3:    return '{sel: ACCL, cmd: 8'h14, len: 3'd4};
      3'd4:    return '{sel: ACCL, cmd: 8'h16, len: 3'd4};
      default: return '{sel: GYRO, cmd: 8'h02, len: 3'd3};
    endcase
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period divider: one-cycle tick every SAMPLE_DIV enabled cycles,
// counter held at zero while disabled so the first tick is a full period away.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == CNT_LAST);

  // Next count: advance while enabled, wrap on the tick, park at zero when off.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q + 1'b1;
    if (!enable_i || tick_o) cnt_d = '0;
  end

  // Divider state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_sample_scheduler.sv
// Periodic frame scheduler for the shared SPI master: five register reads per
// sample tick, assembled into one coherent frame with a single valid pulse.
// Also flags dropped ticks (overrun) and a hung master (timeout_err).
module spi_sample_scheduler
  import spi_sensor_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear_err,
  output logic        sensor_select,
  output logic        write_start,
  output logic [7:0]  write_data,
  output logic [2:0]  write_count_bytes,
  input  logic        write_ready,
  input  logic        read_valid,
  input  logic [7:0]  read_data,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] accl_x,
  output logic [15:0] accl_y,
  output logic [15:0] accl_z,
  output logic        sample_valid,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic             tick;
  state_e           state_q;
  slot_t            slot_q;
  logic [2:0]       byte_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             first_q;      // first WAIT cycle: write_ready not yet meaningful
  logic [15:0]      shadow_q [NUM_SLOTS];

  slot_cfg_t first_cfg, next_cfg;
  logic      wait_exit, tmo_hit, ovr_set;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_i (enable),
    .tick_o   (tick)
  );

  assign first_cfg = slot_cfg(slot_t'(0));
  assign next_cfg  = slot_cfg(slot_q + 3'd1);

  // Transaction is over once all bytes arrived and the master reports idle.
  assign wait_exit = (state_q == ST_WAIT) && !first_q && write_ready &&
                     (byte_cnt_q == write_count_bytes);
  assign tmo_hit   = (state_q == ST_WAIT) && !wait_exit && (tmo_cnt_q == TMO_LAST);
  assign ovr_set   = tick && (state_q != ST_IDLE);

  // Frame FSM with registered command, sample and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      slot_q            <= '0;
      byte_cnt_q        <= '0;
      tmo_cnt_q         <= '0;
      first_q           <= 1'b0;
      // NOTE: the shadow array is only five words, so it is reset with the rest
      // instead of being left as uninitialised storage.
      for (int i = 0; i < NUM_SLOTS; i++) shadow_q[i] <= '0;
      sensor_select     <= 1'b0;
      write_start       <= 1'b0;
      write_data        <= '0;
      write_count_bytes <= '0;
      gyro_x            <= '0;
      gyro_y            <= '0;
      accl_x            <= '0;
      accl_y            <= '0;
      accl_z            <= '0;
      sample_valid      <= 1'b0;
      overrun           <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      write_start  <= 1'b0;
      sample_valid <= 1'b0;
      // Sticky flags: a set event in the clearing cycle still wins.
      overrun      <= ovr_set | (overrun & ~clear_err);
      timeout_err  <= tmo_hit | (timeout_err & ~clear_err);

      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            slot_q <= '0;
            {sensor_select, write_data, write_count_bytes} <= first_cfg;
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (write_ready) begin
            write_start <= 1'b1;
            byte_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            first_q     <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          first_q <= 1'b0;
          // Last two bytes of the transaction carry LSB then MSB; extras are dropped.
          if (read_valid && (byte_cnt_q < write_count_bytes)) begin
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == write_count_bytes - 3'd2) shadow_q[slot_q][7:0]  <= read_data;
            if (byte_cnt_q == write_count_bytes - 3'd1) shadow_q[slot_q][15:8] <= read_data;
          end
          if (wait_exit) begin
            if (slot_q == LAST_SLOT) begin
              state_q <= ST_PUBLISH;
            end else begin
              slot_q  <= slot_q + 3'd1;
              {sensor_select, write_data, write_count_bytes} <= next_cfg;
              state_q <= ST_ISSUE;
            end
          end else if (tmo_hit) begin
            state_q <= ST_IDLE;   // abandon frame, published samples untouched
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        ST_PUBLISH: begin
          gyro_x       <= shadow_q[0];
          gyro_y       <= shadow_q[1];
          accl_x       <= shadow_q[2];
          accl_y       <= shadow_q[3];
          accl_z       <= shadow_q[4];
          sample_valid <= 1'b1;
          state_q      <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// Directed bench for spi_sample_scheduler: behavioural SPI master/sensor,
// scoreboard queues for expected transactions and frames.
module tb_spi_sample_scheduler;

  localparam int SAMPLE_DIV = 16;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        reset_n, enable, clear_err;
  logic        write_ready, read_valid;
  logic [7:0]  read_data;
  logic        sensor_select, write_start, sample_valid, overrun, timeout_err;
  logic [7:0]  write_data;
  logic [2:0]  write_count_bytes;
  logic [15:0] gyro_x, gyro_y, accl_x, accl_y, accl_z;

  spi_sample_scheduler #(.SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .clear_err         (clear_err),
    .sensor_select     (sensor_select),
    .write_start       (write_start),
    .write_data        (write_data),
    .write_count_bytes (write_count_bytes),
    .write_ready       (write_ready),
    .read_valid        (read_valid),
    .read_data         (read_data),
    .gyro_x            (gyro_x),
    .gyro_y            (gyro_y),
    .accl_x            (accl_x),
    .accl_y            (accl_y),
    .accl_z            (accl_z),
    .sample_valid      (sample_valid),
    .overrun           (overrun),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor data model and master behaviour knobs.
  logic [7:0]  seed = 8'h00;
  bit          stall_mode = 1'b0;
  bit          hang_mode  = 1'b0;
  int          release_cyc = 0;
  int          slot0_cyc = 0, slot1_cyc = 0, slot2_cyc = 0;
  int          starts_seen = 0, frames_seen = 0;
  logic [11:0] txn_q [$];
  logic [79:0] frame_q [$];
  logic [79:0] last_frame = '0;
  logic [7:0]  m_cmd;
  int          m_n;
  logic [15:0] m_word;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input bit cond);
    chk(tag, 128'(cond), 128'd1);
  endtask

  // Value the sensor returns for a register read, {MSB, LSB}.
  function automatic logic [15:0] sensor_word(input logic [7:0] cmd, input logic [7:0] sd);
    logic [7:0] msb, lsb;
    msb = 8'h10 + cmd + sd;
    lsb = 8'h32 + cmd + sd;
    return {msb, lsb};
  endfunction

  function automatic logic [11:0] exp_txn(input int s);
    case (s)
      0:       return {1'b0, 8'h02, 3'd3};
      1:       return {1'b0, 8'h04, 3'd3};
      2:       return {1'b1, 8'h12, 3'd4};
      3:       return {1'b1, 8'h14, 3'd4};
      default: return {1'b1, 8'h16, 3'd4};
    endcase
  endfunction

  function automatic logic [127:0] outs();
    return 128'({sensor_select, write_start, write_data, write_count_bytes,
                 gyro_x, gyro_y, accl_x, accl_y, accl_z,
                 sample_valid, overrun, timeout_err});
  endfunction

  task automatic push_frame(input int n_txn, input bit with_frame);
    for (int s = 0; s < n_txn; s++) txn_q.push_back(exp_txn(s));
    if (with_frame) begin
      last_frame = {sensor_word(8'h02, seed), sensor_word(8'h04, seed),
                    sensor_word(8'h12, seed), sensor_word(8'h14, seed),
                    sensor_word(8'h16, seed)};
      frame_q.push_back(last_frame);
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (starts_seen < n && k < budget) begin @(negedge clk); k++; end
    chk_b(tag, starts_seen >= n);
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frames_seen < n && k < budget) begin @(negedge clk); k++; end
    chk_b(tag, frames_seen >= n);
  endtask

  // Behavioural SPI master + sensor: answers each write_start with
  // write_count_bytes bytes (dummies, LSB, MSB) plus one stray byte.
  initial begin
    write_ready = 1'b1;
    read_valid  = 1'b0;
    read_data   = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && write_start === 1'b1) begin
        m_cmd  = write_data;
        m_n    = int'(write_count_bytes);
        m_word = sensor_word(m_cmd, seed);
        write_ready = 1'b0;
        for (int i = 0; i < m_n; i++) begin
          @(negedge clk);
          read_valid = 1'b1;
          read_data  = (i == m_n - 2) ? m_word[7:0] : (i == m_n - 1) ? m_word[15:8] : 8'hA5;
          @(negedge clk);
          read_valid = 1'b0;
        end
        read_valid = 1'b1;
        read_data  = 8'hEE;
        @(negedge clk);
        read_valid = 1'b0;
        if (hang_mode && m_cmd == 8'h04) while (hang_mode) @(negedge clk);
        write_ready = 1'b1;
        if (stall_mode && m_cmd == 8'h04) begin
          @(negedge clk);
          write_ready = 1'b0;
          repeat (20) @(negedge clk);
          release_cyc = cyc;
          write_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every write_start and sample_valid.
  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1 && write_start === 1'b1) begin
      if (write_data == 8'h02) slot0_cyc = cyc;
      if (write_data == 8'h04) slot1_cyc = cyc;
      if (write_data == 8'h12) slot2_cyc = cyc;
      starts_seen++;
      if (txn_q.size() == 0) begin
        total++; bad++;
        $error("FAIL unexpected_start observed=%0h expected=none",
               {sensor_select, write_data, write_count_bytes});
      end else begin
        chk("txn", 128'({sensor_select, write_data, write_count_bytes}), 128'(txn_q.pop_front()));
      end
    end
    if (reset_n === 1'b1 && sample_valid === 1'b1) begin
      frames_seen++;
      if (frame_q.size() == 0) begin
        total++; bad++;
        $error("FAIL unexpected_valid observed=1 expected=0");
      end else begin
        chk("frame", 128'({gyro_x, gyro_y, accl_x, accl_y, accl_z}), 128'(frame_q.pop_front()));
      end
    end
  end

  initial begin
    int t0, base, base_f, k;
    reset_n = 1'b0; enable = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), '0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_disabled", outs(), '0);

    // 1: basic frame, enable dropped right after the first read.
    seed = 8'h00; push_frame(5, 1'b1);
    base = starts_seen; base_f = frames_seen;
    t0 = cyc; enable = 1'b1;
    wait_starts(base + 1, 100, "t1_start");
    enable = 1'b0;
    chk_b("t1_first_tick_latency", (slot0_cyc - t0) >= SAMPLE_DIV && (slot0_cyc - t0) <= SAMPLE_DIV + 2);
    wait_frames(base_f + 1, 400, "t1_frame");
    chk("t1_start_count", 128'(starts_seen - base), 128'd5);
    chk("t1_gyro_x", 128'(gyro_x), 128'h1234);
    chk("t1_flags", 128'({overrun, timeout_err}), '0);
    repeat (40) @(negedge clk);
    chk("t1_single_valid", 128'(frames_seen - base_f), 128'd1);

    // 2: master busy for 20 cycles before slot 2.
    stall_mode = 1'b1; seed = 8'h21; push_frame(5, 1'b1);
    base_f = frames_seen; base = starts_seen;
    enable = 1'b1;
    wait_starts(base + 1, 100, "t2_start");
    enable = 1'b0;
    wait_frames(base_f + 1, 600, "t2_frame");
    stall_mode = 1'b0;
    chk_b("t2_slot2_waits_ready", slot2_cyc > release_cyc && slot2_cyc <= release_cyc + 2);

    // 3: frame longer than the sample period -> overrun, frame still publishes.
    seed = 8'h40; push_frame(5, 1'b1);
    base_f = frames_seen;
    enable = 1'b1;
    k = 0;
    while (overrun !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk_b("t3_overrun_set", overrun === 1'b1);
    enable = 1'b0;
    wait_frames(base_f + 1, 400, "t3_frame");
    chk("t3_overrun_sticky", 128'(overrun), 128'd1);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("t3_overrun_cleared", 128'(overrun), '0);

    // 4: master hangs in slot 1 -> timeout, frame abandoned, outputs held.
    hang_mode = 1'b1; seed = 8'h5A; push_frame(2, 1'b0);
    base = starts_seen; base_f = frames_seen;
    enable = 1'b1;
    wait_starts(base + 1, 100, "t4_start");
    enable = 1'b0;
    k = 0;
    while (timeout_err !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    chk_b("t4_timeout_set", timeout_err === 1'b1);
    chk_b("t4_timeout_latency", (cyc - slot1_cyc) >= TIMEOUT - 1 && (cyc - slot1_cyc) <= TIMEOUT + 1);
    repeat (5) @(negedge clk);
    chk("t4_outputs_held", 128'({gyro_x, gyro_y, accl_x, accl_y, accl_z}), 128'(last_frame));
    chk("t4_no_valid", 128'(frames_seen - base_f), '0);
    chk("t4_start_count", 128'(starts_seen - base), 128'd2);
    hang_mode = 1'b0;
    repeat (4) @(negedge clk);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("t4_timeout_cleared", 128'(timeout_err), '0);
    seed = 8'h3C; push_frame(5, 1'b1);
    base = starts_seen; base_f = frames_seen;
    enable = 1'b1;
    wait_starts(base + 1, 100, "t4_restart");
    enable = 1'b0;
    wait_frames(base_f + 1, 400, "t4_restart_frame");

    // 5: reset asserted during slot 3, then restart from slot 0.
    seed = 8'h66; push_frame(4, 1'b0);
    base = starts_seen;
    enable = 1'b1;
    wait_starts(base + 4, 300, "t5_slot3");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("t5_async_reset", outs(), '0);
    chk("t5_txn_drained", 128'(txn_q.size()), '0);
    repeat (20) @(negedge clk);
    seed = 8'h77; push_frame(5, 1'b1);
    base = starts_seen; base_f = frames_seen;
    t0 = cyc; reset_n = 1'b1;
    wait_starts(base + 1, 100, "t5_restart");
    enable = 1'b0;
    chk_b("t5_tick_after_reset", (slot0_cyc - t0) >= SAMPLE_DIV && (slot0_cyc - t0) <= SAMPLE_DIV + 2);
    wait_frames(base_f + 1, 400, "t5_frame");

    // 6: enable dropped during slot 1 -> frame completes, nothing more.
    seed = 8'h88; push_frame(5, 1'b1);
    base = starts_seen; base_f = frames_seen;
    enable = 1'b1;
    wait_starts(base + 2, 200, "t6_slot1");
    enable = 1'b0;
    wait_frames(base_f + 1, 400, "t6_frame");
    repeat (3 * SAMPLE_DIV) @(negedge clk);
    chk("t6_no_restart", 128'(starts_seen - base), 128'd5);

    chk("end_txn_queue", 128'(txn_q.size()), '0);
    chk("end_frame_queue", 128'(frame_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
